// File: rtl/countdown_timer16_if.sv
// Control and status bundle for the countdown timer.
// The master drives commands and the slave (the timer) returns its status.
interface countdown_timer16_if #(
    parameter int unsigned WIDTH = 16
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
    logic             tick;
    logic [WIDTH-1:0] count;
    logic             running;
    logic             done;
    logic             zero;

    modport master (
        output load, load_val, start, stop, tick,
        input  count, running, done, zero
    );

    modport slave (
        input  load, load_val, start, stop, tick,
        output count, running, done, zero
    );
endinterface

// File: rtl/countdown_timer16.sv
// Loadable down-counter with start/stop control, expiry pulse and optional auto-reload.
// The decrement is a half-subtractor ripple; expiry is detected at 1, so the count never wraps.
module countdown_timer16 #(
    parameter int unsigned WIDTH       = 16,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    countdown_timer16_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] count_dec;
    logic [WIDTH-1:0] borrow;

    // count - 1: borrow-in of 1 rippling up through half-subtractor cells
    assign borrow[0] = 1'b1;
    for (genvar i = 0; i < WIDTH; i++) begin : g_hsub
        assign count_dec[i] = count_q[i] ^ borrow[i];
        if (i < WIDTH - 1) begin : g_borrow
            assign borrow[i+1] = ~count_q[i] & borrow[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (bus.load) begin
            count_d  = bus.load_val;
            reload_d = bus.load_val;
            state_d  = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (count_q != '0) state_d = ST_RUN;
                        else               done_d  = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        state_d = ST_PAUSE;
                    end else if (bus.tick) begin
                        if (count_q == WIDTH'(1)) begin
                            done_d = 1'b1;
                            if (AUTO_RELOAD) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = ST_IDLE;
                            end
                        end else if (count_q != '0) begin
                            count_d = count_dec;
                        end else begin
                            // zero in RUN is unreachable; fall back to IDLE rather than wrap
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (bus.start && !bus.stop) state_d = ST_RUN;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;
    assign bus.zero    = (count_q == '0);
endmodule

// File: tb/tb_countdown_timer16.sv
// Scoreboard bench for countdown_timer16: one-shot and auto-reload instances share stimulus,
// a behavioural model queues expected outputs per clock and they are compared after each edge.
module tb_countdown_timer16;
    localparam int unsigned W = 16;

    typedef struct {
        logic [W-1:0] count;
        logic         running;
        logic         done;
        logic         zero;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load, start, stop, tick;
    logic [W-1:0] load_val;

    int checks   = 0;
    int failures = 0;
    int dones0   = 0;
    int dones1   = 0;

    // model state per instance: 0 = one-shot, 1 = auto-reload
    int           m_st  [2];
    logic [W-1:0] m_cnt [2];
    logic [W-1:0] m_rel [2];
    exp_t         sb0[$];
    exp_t         sb1[$];

    always #5 clk = ~clk;

    countdown_timer16_if #(.WIDTH(W)) bus0 ();
    countdown_timer16_if #(.WIDTH(W)) bus1 ();

    assign bus0.load = load;  assign bus0.load_val = load_val;
    assign bus0.start = start; assign bus0.stop = stop; assign bus0.tick = tick;
    assign bus1.load = load;  assign bus1.load_val = load_val;
    assign bus1.start = start; assign bus1.stop = stop; assign bus1.tick = tick;

    countdown_timer16 #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    countdown_timer16 #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_cnt[k] = '0; m_rel[k] = '0;
        end
    endtask

    // advance the model by one clock using the currently driven inputs
    task automatic model_step(input int k, input bit ar, output exp_t e);
        int  cnt;
        bit  dn;
        cnt = int'(m_cnt[k]);
        dn  = 1'b0;
        if (load) begin
            cnt = int'(load_val); m_rel[k] = load_val; m_st[k] = 0;
        end else if (m_st[k] == 0) begin
            if (start) begin
                if (cnt == 0) dn = 1'b1;
                else          m_st[k] = 1;
            end
        end else if (m_st[k] == 1) begin
            if (stop) m_st[k] = 2;
            else if (tick) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    dn = 1'b1;
                    if (ar) cnt = int'(m_rel[k]);
                    else    m_st[k] = 0;
                end
            end
        end else begin
            if (start && !stop) m_st[k] = 1;
        end
        m_cnt[k]  = W'(cnt);
        e.count   = W'(cnt);
        e.running = (m_st[k] == 1);
        e.done    = dn;
        e.zero    = (cnt == 0);
    endtask

    task automatic cycle();
        exp_t e;
        model_step(0, 1'b0, e); sb0.push_back(e);
        model_step(1, 1'b1, e); sb1.push_back(e);
        @(posedge clk);
        #1;
        e = sb0.pop_front();
        check_eq("os.count",   32'(bus0.count),   32'(e.count));
        check_eq("os.running", 32'(bus0.running), 32'(e.running));
        check_eq("os.done",    32'(bus0.done),    32'(e.done));
        check_eq("os.zero",    32'(bus0.zero),    32'(e.zero));
        if (bus0.done) dones0++;
        e = sb1.pop_front();
        check_eq("ar.count",   32'(bus1.count),   32'(e.count));
        check_eq("ar.running", 32'(bus1.running), 32'(e.running));
        check_eq("ar.done",    32'(bus1.done),    32'(e.done));
        check_eq("ar.zero",    32'(bus1.zero),    32'(e.zero));
        if (bus1.done) dones1++;
    endtask

    task automatic drive(input logic l, input logic [W-1:0] lv, input logic s,
                         input logic p, input logic t);
        load = l; load_val = lv; start = s; stop = p; tick = t;
        cycle();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int d0, d1;
        rst_n = 1'b0;
        load = 1'b0; load_val = '0; start = 1'b0; stop = 1'b0; tick = 1'b0;
        model_reset();
        #12;
        check_eq("rst.count",   32'(bus0.count),   32'h0);
        check_eq("rst.running", 32'(bus0.running), 32'h0);
        check_eq("rst.done",    32'(bus0.done),    32'h0);
        check_eq("rst.zero",    32'(bus0.zero),    32'h1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // async reset while running at 0x1234
        drive(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_eq("pre_rst.running", 32'(bus0.running), 32'h1);
        check_eq("pre_rst.count",   32'(bus0.count),   32'h1234);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst.count",   32'(bus0.count),   32'h0);
        check_eq("async_rst.running", 32'(bus0.running), 32'h0);
        check_eq("async_rst.done",    32'(bus1.done),    32'h0);
        check_eq("async_rst.ar_cnt",  32'(bus1.count),   32'h0);
        model_reset();
        rst_n = 1'b1;
        cycle();

        // one-shot: 3,2,1,0 with done in the zero cycle
        d0 = dones0;
        drive(1'b1, 16'd3, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
        ticks(3);
        check_eq("os3.done_now", 32'(bus0.done), 32'h1);
        check_eq("os3.dones",    32'(dones0 - d0), 32'd1);
        ticks(2);

        // full-range run, no wrap
        d0 = dones0; d1 = dones1;
        drive(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
        ticks(65535);
        check_eq("long.count",    32'(bus0.count),   32'h0);
        check_eq("long.ar_count", 32'(bus1.count),   32'hFFFF);
        ticks(3);
        check_eq("long.dones",    32'(dones0 - d0), 32'd1);
        check_eq("long.ar_dones", 32'(dones1 - d1), 32'd1);

        // pause holds the count, done 3 ticks after resume
        drive(1'b1, 16'd5, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        ticks(2);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
        ticks(10);
        check_eq("pause.count",   32'(bus0.count),   32'd3);
        check_eq("pause.running", 32'(bus0.running), 32'h0);
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check_eq("pause.stop_wins", 32'(bus0.running), 32'h0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        d0 = dones0;
        ticks(2);
        check_eq("resume.early", 32'(dones0 - d0), 32'd0);
        ticks(1);
        check_eq("resume.done",  32'(bus0.done), 32'h1);

        // auto-reload period 4, then period 1
        drive(1'b1, 16'd4, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
        d1 = dones1;
        ticks(16);
        check_eq("ar4.dones", 32'(dones1 - d1), 32'd4);
        drive(1'b1, 16'd1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
        d1 = dones1;
        ticks(8);
        check_eq("ar1.dones", 32'(dones1 - d1), 32'd8);

        // load wins over start; start at zero gives one done and stays idle
        drive(1'b1, 16'd7, 1'b1, 1'b0, 1'b1);
        ticks(5);
        check_eq("ldst.count",   32'(bus0.count),   32'd7);
        check_eq("ldst.running", 32'(bus1.running), 32'h0);
        drive(1'b1, 16'd0, 1'b0, 1'b0, 1'b0);
        d0 = dones0; d1 = dones1;
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
        ticks(4);
        check_eq("zstart.dones",    32'(dones0 - d0), 32'd1);
        check_eq("zstart.ar_dones", 32'(dones1 - d1), 32'd1);
        check_eq("zstart.running",  32'(bus0.running), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
